// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC, memory address drive and a small PC/instruction queue to decode.
// Ports: clk, rst_n (async active-low); Addr_sig -> imem byte address (the PC), Inst_sig <- word at Addr_sig;
//        redirect_valid/redirect_target: branch/jump restart; dec_valid/dec_ready/dec_inst/dec_pc: head of queue;
//        misalign_err: one-cycle pulse after a rejected misaligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Addr_sig,
  input  logic [31:0] Inst_sig,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcm_q [DEPTH];
  logic [31:0] pcm_d [DEPTH];
  logic [31:0] inm_q [DEPTH];
  logic [31:0] inm_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic mis_q, mis_d;
  logic redir, pop, push;
  assign Addr_sig     = pc_q;
  assign dec_valid    = count_q != '0;
  assign dec_inst     = dec_valid ? inm_q[head_q] : NOP_INST;
  assign dec_pc       = dec_valid ? pcm_q[head_q] : 32'h0;
  assign misalign_err = mis_q;
  always_comb begin
    // a misaligned redirect is dropped, so fetch carries on as if it never arrived
    redir   = redirect_valid & (redirect_target[1:0] == 2'b00);
    pop     = dec_valid & dec_ready;
    // a pop frees the slot in the same cycle, so a full queue can still accept
    push    = ~redir & ((count_q < FULL) | pop);
    pc_d    = redir ? redirect_target : push ? pc_q + 32'd4 : pc_q;
    pcm_d   = pcm_q;
    inm_d   = inm_q;
    if (push) begin
      pcm_d[tail_q] = pc_q;
      inm_d[tail_q] = Inst_sig;
    end
    head_d  = redir ? '0 : head_q + PW'(pop);
    tail_d  = redir ? '0 : tail_q + PW'(push);
    count_d = redir ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    mis_d   = redirect_valid & (redirect_target[1:0] != 2'b00);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      pcm_q   <= '{default: '0};
      inm_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pcm_q   <= pcm_d;
      inm_q   <= inm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mis_q   <= mis_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit, plus a second instance with RESET_PC at the top of memory.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0, rst2_n = 0;
  logic redirect_valid = 0, dec_ready = 1;
  logic [31:0] redirect_target = 0;
  logic [31:0] addr, inst, dinst, dpc, addr2, inst2, dinst2, dpc2;
  logic dvalid, merr, dvalid2, merr2;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  assign inst  = 32'hA000_0000 + addr;
  assign inst2 = 32'hA000_0000 + addr2;
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .Addr_sig(addr), .Inst_sig(inst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .dec_ready(dec_ready), .dec_valid(dvalid), .dec_inst(dinst), .dec_pc(dpc),
    .misalign_err(merr)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .Addr_sig(addr2), .Inst_sig(inst2),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .dec_ready(1'b1), .dec_valid(dvalid2), .dec_inst(dinst2), .dec_pc(dpc2),
    .misalign_err(merr2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] a);
    chk({tag, " valid"}, {31'b0, dvalid}, {31'b0, v});
    chk({tag, " pc"}, dpc, pc);
    chk({tag, " inst"}, dinst, v ? 32'hA000_0000 + pc : NOP);
    chk({tag, " addr"}, addr, a);
  endtask
  initial begin
    step();
    head("reset", 0, 32'h0, 32'h0);
    chk("reset merr", {31'b0, merr}, 32'h0);
    chk("rst2 addr", addr2, 32'hFFFF_FFFC);
    rst_n = 1; rst2_n = 1;
    step();
    head("t1 c1", 1, 32'h0, 32'h4);
    chk("t5 pc top", dpc2, 32'hFFFF_FFFC);
    chk("t5 addr wrap", addr2, 32'h0);
    step();
    head("t1 c2", 1, 32'h4, 32'h8);
    chk("t5 pc wrap", dpc2, 32'h0);
    chk("t5 inst wrap", dinst2, 32'hA000_0000);
    step();
    head("t1 c3", 1, 32'h8, 32'hC);
    step();
    head("t1 c4", 1, 32'hC, 32'h10);
    rst_n = 0; #1; rst_n = 1; dec_ready = 0;
    repeat (5) step();
    head("t2 stall", 1, 32'h0, 32'h8);
    dec_ready = 1;
    step();
    head("t2 rel1", 1, 32'h4, 32'hC);
    step();
    head("t2 rel2", 1, 32'h8, 32'h10);
    redirect_valid = 1; redirect_target = 32'h40;
    step();
    head("t3 flush", 0, 32'h0, 32'h40);
    redirect_valid = 0;
    step();
    head("t3 target", 1, 32'h40, 32'h44);
    redirect_valid = 1; redirect_target = 32'h42;
    step();
    head("t4 ignored", 1, 32'h44, 32'h48);
    chk("t4 merr pulse", {31'b0, merr}, 32'h1);
    redirect_valid = 0;
    step();
    head("t4 after", 1, 32'h48, 32'h4C);
    chk("t4 merr clear", {31'b0, merr}, 32'h0);
    dec_ready = 0;
    step();
    head("t6 full", 1, 32'h48, 32'h50);
    rst_n = 0; #1;
    head("t6 async", 0, 32'h0, 32'h0);
    #2 rst_n = 1; dec_ready = 1;
    step();
    head("t6 restart", 1, 32'h0, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
